cache_sweep_ctl: RTL and testbench
==================================

Name: cache_sweep_ctl

Overview:
- Sequences KL10 cache sweeps: invalidate, validate (write back) or unload (write back and invalidate), over the whole cache or one page.
- Sits between the APR/CON instruction decode and the MBOX cache pipeline.
- Walks every (set, way) cache slot and hands one slot at a time to the MBOX through a req/ack handshake.
- Produces SWEEP_BUSY and a one-cycle SWEEP_DONE event that feed the APR sweep-done interrupt flag.

Parameters:
- SET_BITS, 7, log2 number of cache sets (128 sets).
- WAY_BITS, 2, log2 number of ways (4 ways).
- PAGE_BITS, 13, width of page number for one-page sweeps.

Ports:
- clk  input  1  EBOX/APR clock; all state changes on posedge.
- RESET_n  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle sweep start strobe from CON.
- func  input  2  sweep kind: 00 = none, 01 = invalidate, 10 = validate, 11 = unload.
- one_page  input  1  restrict sweep to page on page_in.
- page_in  input  PAGE_BITS  page number; sampled with start.
- mbox_hold  input  1  MBOX busy with EBOX/channel traffic; sweep must not issue.
- mbox_ack  input  1  MBOX accepted the current slot request.
- sweep_req  output  1  slot request valid.
- sweep_set  output  SET_BITS  set index of request.
- sweep_way  output  WAY_BITS  way index of request.
- sweep_func  output  2  latched func.
- sweep_one_page  output  1  latched one_page; MBOX compares tag against sweep_page.
- sweep_page  output  PAGE_BITS  latched page.
- SWEEP_BUSY  output  1  sweep in progress.
- SWEEP_DONE  output  1  one-cycle pulse at sweep completion.
- start_ignored  output  1  sticky: start seen while busy; cleared by the next accepted start.

Behaviour:
- Reset (async, RESET_n low): state IDLE, index 0, all outputs 0, latched func/page 0, start_ignored 0. Reset mid-sweep abandons the sweep; no SWEEP_DONE pulse.
- Index: {set, way} counter of SET_BITS+WAY_BITS bits. Way is least significant. Order: set0 way0..3, set1 way0..3, and so on.
- States: IDLE, ISSUE, STEP, DONE.
- IDLE:
  - start & func != 00: latch func, one_page and page; clear index; SWEEP_BUSY = 1 from the next cycle; go ISSUE.
  - start & func == 00: ignored; no busy; no done.
- ISSUE:
  - sweep_req = ~mbox_hold. Set, way and func outputs are stable for the whole ISSUE stay.
  - req & mbox_ack in the same cycle: slot accepted; go STEP.
  - mbox_ack while req is low (hold active): ignored.
  - mbox_hold may rise while waiting; req drops, then reasserts with the same slot.
- STEP:
  - sweep_req = 0.
  - Index at maximum (all ones): go DONE.
  - Otherwise increment index and go ISSUE.
  - Minimum two cycles per slot; full sweep of 512 slots takes at least 1024 cycles plus hold/ack stalls.
- DONE:
  - SWEEP_DONE = 1 for exactly this cycle; SWEEP_BUSY = 0 in this same cycle; index cleared; go IDLE.
  - A start arriving in DONE is treated as in IDLE and takes effect the next cycle.
- Busy:
  - SWEEP_BUSY = 1 in ISSUE and STEP only.
  - A start while busy is dropped and sets start_ignored. Latched func and page are unchanged.
- Outputs are registered except sweep_req, which is the state decode gated by mbox_hold.
- mbox_ack outside ISSUE has no effect.

Test Plan:
- Reset then start, func=01, one_page=0, no hold, ack tied to req → 512 requests, set/way sequence 0/0, 0/1 … 127/3. SWEEP_BUSY high exactly 1024 cycles. One SWEEP_DONE pulse with busy low that cycle.
- start, func=11, one_page=1, page_in=0x0ABC → every request shows sweep_func=11, sweep_one_page=1, sweep_page=0x0ABC. Func stays 11 when func changes mid-sweep.
- During slot set=5 way=2, hold mbox_hold=1 for 10 cycles, with ack pulsed while held → req low throughout; the slot is not consumed; req resumes with set=5 way=2 and completes normally.
- Start again with func=10 at slot 100 → ignored; start_ignored=1; sweep continues with func unchanged. The next accepted start clears start_ignored.
- Drop RESET_n at slot 300 → outputs 0 immediately (async). No SWEEP_DONE pulse. After release, a new start begins at set 0 way 0.
- start with func=00 → no busy, no requests, no done. Back-to-back: start on the same cycle as SWEEP_DONE → new sweep starts; busy rises the following cycle.

Source files
------------

// File: rtl/cache_sweep_ctl.sv
// Cache sweep sequencer: walks every (set, way) slot and hands it to the MBOX
// one at a time for invalidate, validate or unload, over the whole cache or one page.
module cache_sweep_ctl #(
    parameter int unsigned SET_BITS  = 7,
    parameter int unsigned WAY_BITS  = 2,
    parameter int unsigned PAGE_BITS = 13
) (
    input  logic                 clk,
    input  logic                 RESET_n,
    input  logic                 start,
    input  logic [1:0]           func,
    input  logic                 one_page,
    input  logic [PAGE_BITS-1:0] page_in,
    input  logic                 mbox_hold,
    input  logic                 mbox_ack,
    output logic                 sweep_req,
    output logic [SET_BITS-1:0]  sweep_set,
    output logic [WAY_BITS-1:0]  sweep_way,
    output logic [1:0]           sweep_func,
    output logic                 sweep_one_page,
    output logic [PAGE_BITS-1:0] sweep_page,
    output logic                 SWEEP_BUSY,
    output logic                 SWEEP_DONE,
    output logic                 start_ignored
);

    localparam int unsigned IDX_BITS = SET_BITS + WAY_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [IDX_BITS-1:0] idx;
    logic                start_ok;

    assign start_ok  = start & (func != 2'b00);

    // Request is the only unregistered output so MBOX hold withdraws it at once.
    assign sweep_req = (state == ISSUE) & ~mbox_hold;

    // Way is the low field so all ways of a set are visited before the next set.
    assign sweep_set = idx[IDX_BITS-1:WAY_BITS];
    assign sweep_way = idx[WAY_BITS-1:0];

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state          <= IDLE;
            idx            <= '0;
            sweep_func     <= 2'b00;
            sweep_one_page <= 1'b0;
            sweep_page     <= '0;
            SWEEP_BUSY     <= 1'b0;
            SWEEP_DONE     <= 1'b0;
            start_ignored  <= 1'b0;
        end else begin
            SWEEP_DONE <= 1'b0;
            unique case (state)
                // DONE behaves like IDLE so a start on the done cycle is not lost.
                IDLE, DONE: begin
                    idx        <= '0;
                    SWEEP_BUSY <= 1'b0;
                    state      <= IDLE;
                    if (start_ok) begin
                        sweep_func     <= func;
                        sweep_one_page <= one_page;
                        sweep_page     <= page_in;
                        start_ignored  <= 1'b0;
                        SWEEP_BUSY     <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (start) begin
                        start_ignored <= 1'b1;
                    end
                    if (sweep_req && mbox_ack) begin
                        state <= STEP;
                    end
                end
                STEP: begin
                    if (start) begin
                        start_ignored <= 1'b1;
                    end
                    if (&idx) begin
                        SWEEP_BUSY <= 1'b0;
                        SWEEP_DONE <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx   <= idx + IDX_BITS'(1);
                        state <= ISSUE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_sweep_ctl.sv
// Scoreboard bench for cache_sweep_ctl: a slot-list reference model predicts
// every accepted request plus busy/done/start_ignored, checked every cycle.
module tb_cache_sweep_ctl;

    localparam int NSETS = 128;
    localparam int NWAYS = 4;
    localparam int NSLOTS = NSETS * NWAYS;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  func;
    logic        one_page;
    logic [12:0] page_in;
    logic        mbox_hold;
    logic        mbox_ack;
    logic        sweep_req;
    logic [6:0]  sweep_set;
    logic [1:0]  sweep_way;
    logic [1:0]  sweep_func;
    logic        sweep_one_page;
    logic [12:0] sweep_page;
    logic        SWEEP_BUSY;
    logic        SWEEP_DONE;
    logic        start_ignored;

    cache_sweep_ctl #(.SET_BITS(7), .WAY_BITS(2), .PAGE_BITS(13)) dut (
        .clk            (clk),
        .RESET_n        (rst_n),
        .start          (start),
        .func           (func),
        .one_page       (one_page),
        .page_in        (page_in),
        .mbox_hold      (mbox_hold),
        .mbox_ack       (mbox_ack),
        .sweep_req      (sweep_req),
        .sweep_set      (sweep_set),
        .sweep_way      (sweep_way),
        .sweep_func     (sweep_func),
        .sweep_one_page (sweep_one_page),
        .sweep_page     (sweep_page),
        .SWEEP_BUSY     (SWEEP_BUSY),
        .SWEEP_DONE     (SWEEP_DONE),
        .start_ignored  (start_ignored)
    );

    typedef struct {
        logic [6:0]  set;
        logic [1:0]  way;
        logic [1:0]  func;
        logic        op;
        logic [12:0] page;
    } slot_t;

    slot_t q[$];
    int    n_vec = 0;
    int    n_err = 0;

    // model state
    bit m_busy = 0;
    bit m_step = 0;
    bit m_ign  = 0;
    int m_rem  = 0;
    int cd     = 0;

    // stimulus control
    bit rand_mode = 0;
    bit scr       = 0;
    int hold_left = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // MBOX side: either always-ack, or random hold/ack; forced hold window overrides both.
    initial begin
        mbox_hold = 1'b0;
        mbox_ack  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_left > 0) begin
                mbox_hold = 1'b1;
                mbox_ack  = 1'($urandom);
                hold_left--;
            end else if (rand_mode) begin
                mbox_hold = ($urandom % 5) == 0;
                mbox_ack  = ($urandom % 3) != 0;
            end else begin
                mbox_hold = 1'b0;
                mbox_ack  = 1'b1;
            end
        end
    end

    // Reference model and monitor: one sweep = ordered list of all slots; each
    // accepted slot costs one extra cycle; done follows the last slot's step.
    always @(negedge clk) begin
        bit    exp_done;
        bit    exp_req;
        bit    nb;
        bit    nstep;
        slot_t e;
        if (!rst_n) begin
            q.delete();
            m_busy = 0;
            m_step = 0;
            m_ign  = 0;
            m_rem  = 0;
            cd     = 0;
        end else begin
            exp_done = (cd == 1);
            if (cd > 0) cd--;
            exp_req = m_busy && !m_step && !mbox_hold;
            chk("busy", 32'(SWEEP_BUSY), 32'(m_busy));
            chk("done", 32'(SWEEP_DONE), 32'(exp_done));
            chk("start_ignored", 32'(start_ignored), 32'(m_ign));
            chk("req", 32'(sweep_req), 32'(exp_req));
            nb    = m_busy;
            nstep = 0;
            if (m_step && m_rem == 0) nb = 0;
            if (exp_req && mbox_ack) begin
                if (q.size() == 0) begin
                    chk("slot_queue_underflow", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    chk("slot",
                        32'({sweep_set, sweep_way, sweep_func, sweep_one_page, sweep_page}),
                        32'({e.set, e.way, e.func, e.op, e.page}));
                end
                m_rem--;
                nstep = 1;
                if (m_rem == 0) cd = 2;
            end
            if (start) begin
                if (m_busy) begin
                    m_ign = 1;
                end else if (func != 2'b00) begin
                    for (int i = 0; i < NSLOTS; i++)
                        q.push_back('{set: 7'(i / NWAYS), way: 2'(i % NWAYS),
                                      func: func, op: one_page, page: page_in});
                    m_rem = NSLOTS;
                    m_ign = 0;
                    nb    = 1;
                end
            end
            m_busy = nb;
            m_step = nstep;
        end
    end

    task automatic scramble();
        func     = 2'($urandom);
        one_page = 1'($urandom);
        page_in  = 13'($urandom);
    endtask

    task automatic do_start(input logic [1:0] f, input logic op, input logic [12:0] pg);
        @(posedge clk);
        #1;
        start    = 1'b1;
        func     = f;
        one_page = op;
        page_in  = pg;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns at the negedge where the slot (optionally in its step cycle) shows.
    task automatic wait_slot(input int s, input int w, input bit need_step);
        bit ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (32'(sweep_set) == s && 32'(sweep_way) == w &&
                (!need_step || (SWEEP_BUSY && !sweep_req && !mbox_hold))) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            if (scr) scramble();
        end
        chk($sformatf("reach_slot_%0d_%0d", s, w), 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input int limit);
        bit ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (SWEEP_DONE) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
            if (scr) scramble();
        end
        chk("done_seen", 32'(ok), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   32'(sweep_req), 32'd0);
        chk({tag, "_set"},   32'(sweep_set), 32'd0);
        chk({tag, "_way"},   32'(sweep_way), 32'd0);
        chk({tag, "_func"},  32'(sweep_func), 32'd0);
        chk({tag, "_op"},    32'(sweep_one_page), 32'd0);
        chk({tag, "_page"},  32'(sweep_page), 32'd0);
        chk({tag, "_busy"},  32'(SWEEP_BUSY), 32'd0);
        chk({tag, "_done"},  32'(SWEEP_DONE), 32'd0);
        chk({tag, "_ign"},   32'(start_ignored), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int  busy_cnt;
        bit  seen;
        rst_n    = 1'b0;
        start    = 1'b0;
        func     = 2'b00;
        one_page = 1'b0;
        page_in  = '0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full invalidate with ack always on: busy exactly two cycles per slot.
        do_start(2'b01, 1'b0, 13'h0000);
        busy_cnt = 0;
        seen     = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (SWEEP_BUSY) busy_cnt++;
            if (SWEEP_DONE) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("sweep_a_done", 32'(seen), 32'd1);
        chk("busy_cycles", 32'(busy_cnt), 32'd1024);
        chk("queue_empty_a", 32'(q.size()), 32'd0);

        // One-page unload under random hold/ack, inputs scrambled mid-sweep.
        do_start(2'b11, 1'b1, 13'h0ABC);
        @(negedge clk);
        rand_mode = 1;
        scr       = 1;
        wait_slot(25, 0, 0);
        @(posedge clk);
        #1;
        start = 1'b1;
        func  = 2'b10;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("ignored_set", 32'(start_ignored), 32'd1);
        wait_done(20000);
        chk("queue_empty_b", 32'(q.size()), 32'd0);
        rand_mode = 0;
        scr       = 0;

        // Validate sweep: clears start_ignored, forced hold on slot 5/2, reset mid-sweep.
        do_start(2'b10, 1'b0, 13'h1234);
        @(negedge clk);
        chk("ignored_cleared", 32'(start_ignored), 32'd0);
        wait_slot(5, 1, 1);
        hold_left = 10;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("held_req", 32'(sweep_req), 32'd0);
            chk("held_slot", 32'({sweep_set, sweep_way}), 32'({7'd5, 2'd2}));
        end
        wait_slot(75, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fresh sweep after reset, then a back-to-back start on the done cycle.
        do_start(2'b01, 1'b0, 13'h0000);
        wait_slot(127, 3, 1);
        @(posedge clk);
        #1;
        start    = 1'b1;
        func     = 2'b11;
        one_page = 1'b0;
        page_in  = 13'h1FFF;
        @(negedge clk);
        chk("b2b_done", 32'(SWEEP_DONE), 32'd1);
        chk("b2b_busy_low", 32'(SWEEP_BUSY), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b_busy_high", 32'(SWEEP_BUSY), 32'd1);
        rand_mode = 1;
        wait_done(20000);
        rand_mode = 0;
        chk("queue_empty_d", 32'(q.size()), 32'd0);

        // func 00 start does nothing.
        do_start(2'b00, 1'b1, 13'h0005);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("nop_busy", 32'(SWEEP_BUSY), 32'd0);
        end
        chk("queue_empty_end", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
